// File: rtl/seg_scan_sched.sv
// seg_scan_sched: round-robin scheduler that time-multiplexes one active-low
// 7-segment bus across NUM_DIGITS digits, with a blanking gap between digits.
// Optional feature macro: SEG_SCAN_DIM_EN (adds a 4-bit duty input for dimming).
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   digit_vals hex value per digit, digit i = bits [4i+3:4i]
//   digit_en   per-digit enable mask, disabled digits are skipped
//   duty       (SEG_SCAN_DIM_EN only) lit fraction of the dwell, in 16ths
//   seg        {g,f,e,d,c,b,a}, active-low, registered
//   an         anode enables, active-low, at most one low, registered
//   cur_digit  index of the digit owning the bus, registered
//   scan_wrap  one-cycle pulse when the round-robin pointer wraps
module seg_scan_sched #(
   parameter int unsigned NUM_DIGITS   = 2,
   parameter int unsigned DWELL_CYCLES = 24000,
   parameter int unsigned BLANK_CYCLES = 120
) (
   input  logic                                                  clk,
   input  logic                                                  reset,
   input  logic [4*NUM_DIGITS-1:0]                               digit_vals,
   input  logic [NUM_DIGITS-1:0]                                 digit_en,
`ifdef SEG_SCAN_DIM_EN
   input  logic [3:0]                                            duty,
`endif
   output logic [6:0]                                            seg,
   output logic [NUM_DIGITS-1:0]                                 an,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] cur_digit,
   output logic                                                  scan_wrap
);

   localparam int unsigned CW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
`ifdef SEG_SCAN_DIM_EN
   localparam int unsigned DW16    = DWELL_CYCLES / 16;
`endif

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [CNTW-1:0]       cnt_q, cnt_d;
   logic [CW-1:0]         last_q, last_d;
   logic [CW-1:0]         cur_q, cur_d;
   logic [3:0]            val_q, val_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  wrap_q, wrap_d;
`ifdef SEG_SCAN_DIM_EN
   logic [CNTW-1:0]       on_q, on_d;
`endif

   logic                  found;
   logic [CW-1:0]         pick;
   logic                  lit;

   // Hex to active-low {g..a}
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         last_q  <= CW'(NUM_DIGITS - 1);
         cur_q   <= '0;
         val_q   <= '0;
         seg_q   <= 7'h7F;
         an_q    <= '1;
         wrap_q  <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
         on_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         cur_q   <= cur_d;
         val_q   <= val_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         wrap_q  <= wrap_d;
`ifdef SEG_SCAN_DIM_EN
         on_q    <= on_d;
`endif
      end
   end

   // Next state, arbitration and next outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      cur_d   = cur_q;
      val_d   = val_q;
      wrap_d  = 1'b0;
`ifdef SEG_SCAN_DIM_EN
      on_d    = on_q;
`endif
      found   = 1'b0;
      pick    = '0;
      lit     = 1'b0;

      // Cyclic search from last+1 through last inclusive; first enabled wins
      for (int unsigned k = 1; k <= NUM_DIGITS; k++) begin
         int unsigned           p;
         logic [NUM_DIGITS-1:0] en_sh;
         p = int'(last_q) + k;
         if (p >= NUM_DIGITS) p = p - NUM_DIGITS;
         en_sh = digit_en >> p;
         if (!found && en_sh[0]) begin
            found = 1'b1;
            pick  = CW'(p);
         end
      end

      case (state_q)
         ST_BLANK: begin
            if (cnt_q == CNTW'(BLANK_CYCLES - 1)) begin
               cnt_d = '0;
               if (found) begin
                  state_d = ST_SHOW;
                  last_d  = pick;
                  cur_d   = pick;
                  val_d   = 4'(digit_vals >> {pick, 2'b00});
                  wrap_d  = (pick <= last_q);
`ifdef SEG_SCAN_DIM_EN
                  on_d    = CNTW'(DW16 * duty);
`endif
               end
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         ST_SHOW: begin
            if (cnt_q == CNTW'(DWELL_CYCLES - 1)) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         default: begin
            state_d = ST_BLANK;
            cnt_d   = '0;
         end
      endcase

      // Outputs are computed from next state so they register in step with it
`ifdef SEG_SCAN_DIM_EN
      lit = (state_d == ST_SHOW) && (cnt_d < on_d);
`else
      lit = (state_d == ST_SHOW);
`endif
      an_d  = lit ? ~(NUM_DIGITS'(1) << cur_d) : '1;
      seg_d = lit ? decode(val_d) : 7'h7F;
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign cur_digit = cur_q;
   assign scan_wrap = wrap_q;

endmodule
